// File: rtl/regfile_access_seq.sv
// Initiator-side Register_File sequencer for the non-pipelined microprogrammed RISC-V core.
// Reads two source registers, hands operands to execute, then writes the result back once.
module regfile_access_seq #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  rd_wr,
    output logic                  opnd_valid,
    input  logic                  opnd_ready,
    output logic [XLEN-1:0]       opnd_a,
    output logic [XLEN-1:0]       opnd_b,
    input  logic                  result_valid,
    output logic                  result_ready,
    input  logic [XLEN-1:0]       result_data,
    output logic [REG_ADDR_W-1:0] reg1_addr,
    output logic [REG_ADDR_W-1:0] reg2_addr,
    input  logic [XLEN-1:0]       reg1_data,
    input  logic [XLEN-1:0]       reg2_data,
    output logic                  wrt_en,
    output logic [REG_ADDR_W-1:0] reg_wrt_addr,
    output logic [XLEN-1:0]       reg_wrt_data,
    output logic                  retire,
    output logic [CNT_W-1:0]      retired_count
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        ISSUE,
        WAIT_RES,
        WRITE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [REG_ADDR_W-1:0] rs1_q;
    logic [REG_ADDR_W-1:0] rs2_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  rd_wr_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx     = state;
        instr_ready  = 1'b0;
        opnd_valid   = 1'b0;
        result_ready = 1'b0;
        wrt_en       = 1'b0;
        retire       = 1'b0;

        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_nx = READ;
                end
            end
            READ: begin
                state_nx = ISSUE;
            end
            ISSUE: begin
                opnd_valid = 1'b1;
                if (opnd_ready) begin
                    state_nx = WAIT_RES;
                end
            end
            WAIT_RES: begin
                result_ready = 1'b1;
                if (result_valid) begin
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                retire   = 1'b1;
                wrt_en   = rd_wr_q && (rd_q != '0);
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Reset wins: no handshake or write may be seen by neighbours during the reset cycle.
        if (rst) begin
            instr_ready  = 1'b0;
            opnd_valid   = 1'b0;
            result_ready = 1'b0;
            wrt_en       = 1'b0;
            retire       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            rd_wr_q       <= 1'b0;
            reg1_addr     <= '0;
            reg2_addr     <= '0;
            opnd_a        <= '0;
            opnd_b        <= '0;
            reg_wrt_addr  <= '0;
            reg_wrt_data  <= '0;
            retired_count <= '0;
        end else begin
            // Read addresses are loaded at acceptance so they are already valid throughout READ.
            if (state == IDLE && instr_valid) begin
                rs1_q     <= rs1;
                rs2_q     <= rs2;
                rd_q      <= rd;
                rd_wr_q   <= rd_wr;
                reg1_addr <= rs1;
                reg2_addr <= rs2;
            end

            if (state == READ) begin
                opnd_a <= (rs1_q == '0) ? '0 : reg1_data;
                opnd_b <= (rs2_q == '0) ? '0 : reg2_data;
            end

            if (state == WAIT_RES && result_valid) begin
                reg_wrt_addr <= rd_q;
                reg_wrt_data <= result_data;
            end

            if (state == WRITE) begin
                retired_count <= retired_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_regfile_access_seq.sv
// Self-checking bench for regfile_access_seq: vector table driven through a scoreboard,
// plus hand-written reset, mid-operation reset and counter-wrap sequences.
module tb_regfile_access_seq;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  rs1, rs2, rd;
    logic        rd_wr;
    logic        opnd_valid;
    logic        opnd_ready;
    logic [31:0] opnd_a, opnd_b;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result_data;
    logic [4:0]  reg1_addr, reg2_addr;
    logic [31:0] reg1_data, reg2_data;
    logic        wrt_en;
    logic [4:0]  reg_wrt_addr;
    logic [31:0] reg_wrt_data;
    logic        retire;
    logic [31:0] retired_count;

    // Narrow-counter instance sharing the same stimulus
    logic        w_instr_ready, w_opnd_valid, w_result_ready, w_wrt_en, w_retire;
    logic [31:0] w_opnd_a, w_opnd_b, w_reg1_data, w_reg2_data, w_reg_wrt_data;
    logic [4:0]  w_reg1_addr, w_reg2_addr, w_reg_wrt_addr;
    logic [3:0]  w_retired_count;

    logic [31:0] rf [32];

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int exp_count  = 0;

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic        rd_wr;
        logic [31:0] result;
        int          opnd_hold;
        int          res_hold;
        bit          poke;
        logic [31:0] exp_a, exp_b;
        logic        exp_wr;
    } vec_t;

    typedef struct {
        logic [31:0] a, b;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];

    regfile_access_seq #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .rd_wr(rd_wr),
        .opnd_valid(opnd_valid), .opnd_ready(opnd_ready),
        .opnd_a(opnd_a), .opnd_b(opnd_b),
        .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data),
        .reg1_addr(reg1_addr), .reg2_addr(reg2_addr),
        .reg1_data(reg1_data), .reg2_data(reg2_data),
        .wrt_en(wrt_en), .reg_wrt_addr(reg_wrt_addr), .reg_wrt_data(reg_wrt_data),
        .retire(retire), .retired_count(retired_count)
    );

    regfile_access_seq #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(w_instr_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .rd_wr(rd_wr),
        .opnd_valid(w_opnd_valid), .opnd_ready(opnd_ready),
        .opnd_a(w_opnd_a), .opnd_b(w_opnd_b),
        .result_valid(result_valid), .result_ready(w_result_ready), .result_data(result_data),
        .reg1_addr(w_reg1_addr), .reg2_addr(w_reg2_addr),
        .reg1_data(w_reg1_data), .reg2_data(w_reg2_data),
        .wrt_en(w_wrt_en), .reg_wrt_addr(w_reg_wrt_addr), .reg_wrt_data(w_reg_wrt_data),
        .retire(w_retire), .retired_count(w_retired_count)
    );

    assign reg1_data   = rf[reg1_addr];
    assign reg2_data   = rf[reg2_addr];
    assign w_reg1_data = rf[w_reg1_addr];
    assign w_reg2_data = rf[w_reg2_addr];

    // Register_File model: written only by the main instance's write port
    always @(posedge clk) begin
        if (wrt_en) rf[reg_wrt_addr] <= reg_wrt_data;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assert_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        assert_cnt++;
        fail_cnt++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        instr_valid  = 1'b0;
        opnd_ready   = 1'b0;
        result_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_instr_ready",   32'(instr_ready), 32'd0);
        check("rst_opnd_valid",    32'(opnd_valid), 32'd0);
        check("rst_result_ready",  32'(result_ready), 32'd0);
        check("rst_wrt_en",        32'(wrt_en), 32'd0);
        check("rst_retire",        32'(retire), 32'd0);
        check("rst_opnd_a",        opnd_a, 32'd0);
        check("rst_opnd_b",        opnd_b, 32'd0);
        check("rst_reg1_addr",     32'(reg1_addr), 32'd0);
        check("rst_reg2_addr",     32'(reg2_addr), 32'd0);
        check("rst_reg_wrt_addr",  32'(reg_wrt_addr), 32'd0);
        check("rst_reg_wrt_data",  reg_wrt_data, 32'd0);
        check("rst_retired_count", retired_count, 32'd0);
        check("rst_w_count",       32'(w_retired_count), 32'd0);
        rst       = 1'b0;
        exp_count = 0;
        @(negedge clk);
        check("post_rst_instr_ready", 32'(instr_ready), 32'd1);
        check("post_rst_opnd_valid",  32'(opnd_valid), 32'd0);
        check("post_rst_wrt_en",      32'(wrt_en), 32'd0);
    endtask

    // Drives one instruction from a negedge in IDLE, applies the requested backpressure and
    // checks operands, write-back, latency and count against the scoreboard.
    task automatic send(input vec_t v);
        int   n, oh, rh;
        bit   done;
        exp_t e;
        n = 0;
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) fail_now("wait_instr_ready");

        e.a = v.exp_a; e.b = v.exp_b; e.wr = v.exp_wr; e.addr = v.rd; e.data = v.result;
        sb.push_back(e);
        instr_valid  = 1'b1;
        rs1          = v.rs1;
        rs2          = v.rs2;
        rd           = v.rd;
        rd_wr        = v.rd_wr;
        opnd_ready   = (v.opnd_hold == 0);
        result_valid = (v.res_hold == 0);
        result_data  = v.result;
        @(posedge clk);

        n = 0; oh = 0; rh = 0; done = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
            if (v.poke) begin
                instr_valid = 1'b1;
                rs1 = 5'd31; rs2 = 5'd31; rd = 5'd31; rd_wr = 1'b1;
            end else begin
                instr_valid = 1'b0;
            end
            check("busy_instr_ready", 32'(instr_ready), 32'd0);
            if (opnd_valid) begin
                if (sb.size() > 0) begin
                    check("opnd_a", opnd_a, sb[0].a);
                    check("opnd_b", opnd_b, sb[0].b);
                end
                if (oh == v.opnd_hold) opnd_ready = 1'b1;
                else begin opnd_ready = 1'b0; oh++; end
            end
            if (result_ready) begin
                if (rh == v.res_hold) result_valid = 1'b1;
                else begin result_valid = 1'b0; rh++; end
            end
            if (retire) begin
                if (sb.size() == 0) fail_now("scoreboard_empty");
                else begin
                    e = sb.pop_front();
                    check("wrt_en", 32'(wrt_en), 32'(e.wr));
                    check("reg_wrt_data", reg_wrt_data, e.data);
                    if (e.wr) check("reg_wrt_addr", 32'(reg_wrt_addr), 32'(e.addr));
                end
                check("latency", 32'(n), 32'(4 + oh + rh));
                exp_count++;
                done         = 1;
                instr_valid  = 1'b0;
                opnd_ready   = 1'b0;
                result_valid = 1'b0;
            end else begin
                check("no_write", 32'(wrt_en), 32'd0);
            end
        end
        if (!done) begin
            fail_now("wait_retire");
            return;
        end
        @(negedge clk);
        check("after_retire", 32'(retire), 32'd0);
        check("after_wrt_en", 32'(wrt_en), 32'd0);
        check("after_instr_ready", 32'(instr_ready), 32'd1);
        check("retired_count", retired_count, 32'(exp_count));
        check("hold_wrt_data", reg_wrt_data, v.result);
    endtask

    initial begin
        vecs[0] = '{rs1:5'd0,  rs2:5'd0,  rd:5'd5,  rd_wr:1'b1, result:32'h0000_0001,
                    opnd_hold:0, res_hold:0, poke:1'b0,
                    exp_a:32'h0, exp_b:32'h0, exp_wr:1'b1};
        vecs[1] = '{rs1:5'd5,  rs2:5'd5,  rd:5'd10, rd_wr:1'b1, result:32'd10,
                    opnd_hold:0, res_hold:0, poke:1'b0,
                    exp_a:32'h1, exp_b:32'h1, exp_wr:1'b1};
        vecs[2] = '{rs1:5'd0,  rs2:5'd3,  rd:5'd4,  rd_wr:1'b1, result:32'h55,
                    opnd_hold:0, res_hold:0, poke:1'b0,
                    exp_a:32'h0, exp_b:32'hDEAD_BEEF, exp_wr:1'b1};
        vecs[3] = '{rs1:5'd10, rs2:5'd3,  rd:5'd0,  rd_wr:1'b1, result:32'h99,
                    opnd_hold:0, res_hold:0, poke:1'b0,
                    exp_a:32'd10, exp_b:32'hDEAD_BEEF, exp_wr:1'b0};
        vecs[4] = '{rs1:5'd4,  rs2:5'd10, rd:5'd6,  rd_wr:1'b0, result:32'h77,
                    opnd_hold:0, res_hold:0, poke:1'b0,
                    exp_a:32'h55, exp_b:32'd10, exp_wr:1'b0};
        vecs[5] = '{rs1:5'd3,  rs2:5'd4,  rd:5'd7,  rd_wr:1'b1, result:32'hA5A5_A5A5,
                    opnd_hold:5, res_hold:7, poke:1'b1,
                    exp_a:32'hDEAD_BEEF, exp_b:32'h55, exp_wr:1'b1};
        vecs[6] = '{rs1:5'd7,  rs2:5'd6,  rd:5'd8,  rd_wr:1'b1, result:32'h1234,
                    opnd_hold:0, res_hold:0, poke:1'b0,
                    exp_a:32'hA5A5_A5A5, exp_b:32'h6666_6666, exp_wr:1'b1};

        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[0] = 32'h1234_5678;
        rf[3] = 32'hDEAD_BEEF;
        rf[6] = 32'h6666_6666;
        rs1 = '0; rs2 = '0; rd = '0; rd_wr = 1'b0; result_data = '0;

        do_reset();
        for (int i = 0; i < 7; i++) send(vecs[i]);
        check("rf_x0_untouched", rf[0], 32'h1234_5678);
        check("rf_x6_unwritten", rf[6], 32'h6666_6666);

        // Reset during WAIT_RES with a result offered in the same cycle
        do_reset();
        instr_valid  = 1'b1;
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd7; rd_wr = 1'b1;
        opnd_ready   = 1'b1;
        result_valid = 1'b0;
        result_data  = 32'h0BAD_0BAD;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        begin
            int n;
            n = 0;
            while (!result_ready && n < 10) begin
                check("midrst_no_write", 32'(wrt_en), 32'd0);
                @(negedge clk);
                n++;
            end
            if (!result_ready) fail_now("wait_result_ready");
        end
        rst          = 1'b1;
        result_valid = 1'b1;
        check("midrst_wrt_en_in_rst", 32'(wrt_en), 32'd0);
        @(negedge clk);
        check("midrst_wrt_en", 32'(wrt_en), 32'd0);
        check("midrst_retire", 32'(retire), 32'd0);
        check("midrst_count", retired_count, 32'd0);
        rst          = 1'b0;
        result_valid = 1'b0;
        @(negedge clk);
        check("midrst_idle", 32'(instr_ready), 32'd1);
        check("midrst_count_after", retired_count, 32'd0);
        check("midrst_wrt_en_after", 32'(wrt_en), 32'd0);
        check("midrst_rf_x7", rf[7], 32'hA5A5_A5A5);

        // Counter wrap on the 4-bit instance
        for (int i = 0; i < 17; i++) begin
            vec_t v;
            v = '{rs1:5'd0, rs2:5'd0, rd:5'd9, rd_wr:1'b1, result:32'(i + 100),
                  opnd_hold:0, res_hold:0, poke:1'b0,
                  exp_a:32'h0, exp_b:32'h0, exp_wr:1'b1};
            send(v);
        end
        check("wrap_count_w", 32'(w_retired_count), 32'd1);
        check("wrap_count_main", retired_count, 32'd17);
        check("rf_x9_last", rf[9], 32'd116);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
